rx_block_lock_fsm: RTL and testbench

RX_BLOCK_LOCK_FSM -- requirements
Module: rx_block_lock_fsm

---
 rtl/rx_block_lock_fsm.sv | 130 +++++++++++++
 tb/tb_rx_block_lock_fsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_lock_fsm.sv
// 64b/66b receive block-lock state machine: hunts for sync-header alignment by
// issuing bitslip pulses. Optional statistics counters with RX_BLOCK_LOCK_STATS_EN.
module rx_block_lock_fsm #(
  parameter int SH_WINDOW   = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [1:0]  sync_hdr,
`ifdef RX_BLOCK_LOCK_STATS_EN
  input  logic        clear_stats,
  output logic [15:0] hdr_err_count,
  output logic [15:0] slip_count,
`endif
  output logic        bitslip,
  output logic        block_lock
);

  localparam int CNT_W  = $clog2(SH_WINDOW + 1);
  localparam int INV_W  = $clog2(INVALID_MAX + 1);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  typedef enum logic [2:0] {
    ST_LOCK_INIT,
    ST_RESET_CNT,
    ST_TEST_SH,
    ST_SLIP,
    ST_SLIP_WAIT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_sh_cnt;
  logic [INV_W-1:0]   r_inv_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_bitslip;
  logic               r_block_lock;

  logic               w_hdr_bad;
  logic               w_test_blk;
  logic               w_slip_evt;
  logic [CNT_W-1:0]   w_sh_next;
  logic [INV_W-1:0]   w_inv_next;

  assign w_hdr_bad  = ~(sync_hdr[1] ^ sync_hdr[0]);
  assign w_test_blk = (r_state == ST_TEST_SH) && valid_in;
  assign w_sh_next  = r_sh_cnt + 1'b1;
  assign w_inv_next = r_inv_cnt + INV_W'(w_hdr_bad);
  // Any bad header slips while hunting; once locked only a full budget of errors does.
  assign w_slip_evt = w_test_blk && w_hdr_bad &&
                      (!r_block_lock || (w_inv_next == INV_W'(INVALID_MAX)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_LOCK_INIT;
      r_sh_cnt     <= '0;
      r_inv_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_bitslip    <= 1'b0;
      r_block_lock <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      case (r_state)
        ST_LOCK_INIT: r_state <= ST_RESET_CNT;
        ST_RESET_CNT: begin
          r_sh_cnt  <= '0;
          r_inv_cnt <= '0;
          r_state   <= ST_TEST_SH;
        end
        ST_TEST_SH: begin
          if (valid_in) begin
            r_sh_cnt  <= w_sh_next;
            r_inv_cnt <= w_inv_next;
            if (w_slip_evt) begin
              r_bitslip    <= 1'b1;
              r_block_lock <= 1'b0;
              r_state      <= ST_SLIP;
            end else if (w_sh_next == CNT_W'(SH_WINDOW)) begin
              if (w_inv_next == '0) r_block_lock <= 1'b1;
              r_state <= ST_RESET_CNT;
            end
          end
        end
        ST_SLIP: begin
          r_wait_cnt <= '0;
          r_state    <= (SLIP_WAIT == 0) ? ST_RESET_CNT : ST_SLIP_WAIT;
        end
        ST_SLIP_WAIT: begin
          if (valid_in) begin
            if (r_wait_cnt == WAIT_W'(SLIP_WAIT - 1)) r_state <= ST_RESET_CNT;
            else r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= ST_LOCK_INIT;
      endcase
    end
  end

  assign bitslip    = r_bitslip;
  assign block_lock = r_block_lock;

`ifdef RX_BLOCK_LOCK_STATS_EN
  logic [15:0] r_hdr_err_count;
  logic [15:0] r_slip_count;
  logic        w_hdr_evt;

  assign w_hdr_evt = w_test_blk && w_hdr_bad;

  // Slip count steps on the same edge that raises the bitslip pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr_err_count <= '0;
      r_slip_count    <= '0;
    end else if (clear_stats) begin
      r_hdr_err_count <= '0;
      r_slip_count    <= '0;
    end else begin
      if (w_hdr_evt && (r_hdr_err_count != 16'hFFFF))
        r_hdr_err_count <= r_hdr_err_count + 16'd1;
      if (w_slip_evt && (r_slip_count != 16'hFFFF))
        r_slip_count <= r_slip_count + 16'd1;
    end
  end

  assign hdr_err_count = r_hdr_err_count;
  assign slip_count    = r_slip_count;
`endif

endmodule

// File: tb/tb_rx_block_lock_fsm.sv
// Self-checking bench for rx_block_lock_fsm: table of stimulus runs with a
// scoreboard of expected lock/slip outputs, plus reset and statistics sequences.
module tb_rx_block_lock_fsm;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [1:0]  sync_hdr;
  logic        bitslip;
  logic        block_lock;
`ifdef RX_BLOCK_LOCK_STATS_EN
  logic        clear_stats;
  logic [15:0] hdr_err_count;
  logic [15:0] slip_count;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic       vin;
    logic [1:0] hdr;
    int         reps;
    logic       expLock;
    logic       expSlip;
    logic       gap;
  } vec_t;

  typedef struct {
    logic lock;
    logic slip;
  } exp_t;

  vec_t tbl[$];
  exp_t expQ[$];

  rx_block_lock_fsm dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .valid_in      (valid_in),
    .sync_hdr      (sync_hdr),
`ifdef RX_BLOCK_LOCK_STATS_EN
    .clear_stats   (clear_stats),
    .hdr_err_count (hdr_err_count),
    .slip_count    (slip_count),
`endif
    .bitslip       (bitslip),
    .block_lock    (block_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic act, input logic req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %b, required %b at %0t", name, act, req, $time);
  endtask

`ifdef RX_BLOCK_LOCK_STATS_EN
  task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
  endtask
`endif

  task automatic checkOutput(input string tag);
    exp_t e;
    e = expQ.pop_front();
    checkBit({tag, ".block_lock"}, block_lock, e.lock);
    checkBit({tag, ".bitslip"}, bitslip, e.slip);
  endtask

  // Inputs change 1 ns after an edge; outputs are compared 1 ns after the next edge.
  task automatic applyStimulus(input logic v, input logic [1:0] h,
                               input logic eLock, input logic eSlip, input string tag);
    exp_t e;
    valid_in = v;
    sync_hdr = h;
    e.lock = eLock;
    e.slip = eSlip;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic addVec(input logic v, input logic [1:0] h, input int reps,
                        input logic eLock, input logic eSlip, input logic gap);
    vec_t r;
    r.vin = v; r.hdr = h; r.reps = reps;
    r.expLock = eLock; r.expSlip = eSlip; r.gap = gap;
    tbl.push_back(r);
  endtask

  task automatic runTable();
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        if (tbl[i].gap)
          applyStimulus(1'b0, 2'b11, tbl[i].expLock, tbl[i].expSlip, $sformatf("vec%0d.gap", i));
        applyStimulus(tbl[i].vin, tbl[i].hdr, tbl[i].expLock, tbl[i].expSlip, $sformatf("vec%0d", i));
      end
    end
    tbl.delete();
  endtask

  // Holds reset across two edges, checks the cleared outputs, then releases.
  task automatic holdReset(input string tag);
    reset_n = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkBit({tag, ".rst_lock"}, block_lock, 1'b0);
    checkBit({tag, ".rst_slip"}, bitslip, 1'b0);
`ifdef RX_BLOCK_LOCK_STATS_EN
    checkWord({tag, ".rst_hdr_err"}, hdr_err_count, 16'd0);
    checkWord({tag, ".rst_slip_cnt"}, slip_count, 16'd0);
`endif
    reset_n = 1'b1;
  endtask

  task automatic midCycleReset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    checkBit({tag, ".async_lock"}, block_lock, 1'b0);
    checkBit({tag, ".async_slip"}, bitslip, 1'b0);
    holdReset(tag);
  endtask

  // Invalid headers during LOCK_INIT and RESET_CNT must be ignored.
  task automatic initCycles(input string tag);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, {tag, ".init0"});
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, {tag, ".init1"});
  endtask

  task automatic lockRun(input string tag);
    for (int i = 0; i < 63; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, {tag, ".hunt"});
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, {tag, ".lock"});
  endtask

  initial begin
    reset_n  = 1'b0;
    valid_in = 1'b0;
    sync_hdr = 2'b00;
`ifdef RX_BLOCK_LOCK_STATS_EN
    clear_stats = 1'b0;
`endif
    holdReset("por");

    addVec(1'b1, 2'b11,  2, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b01, 63, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b01,  1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b01,  1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b11, 15, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b01, 49, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b01,  1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b00, 15, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b00,  1, 1'b0, 1'b1, 1'b0);
    addVec(1'b1, 2'b01,  1, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b01,  4, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b01,  1, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b01,  2, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b11,  1, 1'b0, 1'b1, 1'b0);
    addVec(1'b1, 2'b01,  1, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 2'b11,  3, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b01,  4, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 2'b01,  1, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b10, 63, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 2'b10,  1, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 2'b10,  1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b10,  1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b01, 48, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b11, 15, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 2'b11,  1, 1'b0, 1'b1, 1'b0);
    runTable();

    // Reset while the bitslip pulse is high, then confirm a full restart.
    midCycleReset("rst_in_slip");
    initCycles("after_slip_rst");
    lockRun("after_slip_rst");

    midCycleReset("rst_locked");

    // Reset in SLIP_WAIT; lock timing afterwards proves a LOCK_INIT restart.
    initCycles("to_wait");
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, "to_wait.slip");
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, "to_wait.slip_state");
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, "to_wait.wait1");
    midCycleReset("rst_in_wait");
    initCycles("after_wait_rst");
    lockRun("after_wait_rst");

`ifdef RX_BLOCK_LOCK_STATS_EN
    holdReset("stats");
    initCycles("stats");
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b1, $sformatf("stats.slip%0d", s));
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, "stats.slip_state");
      for (int w = 0; w < 4; w++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, "stats.wait");
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, "stats.reset_cnt");
    end
    checkWord("stats.slip_count", slip_count, 16'd3);
    checkWord("stats.hdr_err_count", hdr_err_count, 16'd3);
    clear_stats = 1'b1;
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1, "stats.clear_slip");
    clear_stats = 1'b0;
    checkWord("stats.clear_slip_count", slip_count, 16'd0);
    checkWord("stats.clear_hdr_err", hdr_err_count, 16'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, "stats.post_clear");
    checkWord("stats.post_clear_slip", slip_count, 16'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
